// File: rtl/beta_imem_arbiter.sv
// rtl/beta_imem_arbiter.sv - shared memory port arbiter/sequencer for fetch (IF) and load/store (LS)
//
// Ports:
//   clk_i, rstn_i        clock (rising edge), asynchronous active-low reset
//   arb_if_*             fetch request (req/addr/flush in, ready/valid/rdata out)
//   arb_ls_*             load/store request (req/we/be/addr/wdata in, ready/valid/rdata out)
//   arb_mem_*            single memory port, req/ready accept, valid response
//   arb_busy_o           a transaction is presented or outstanding
//   arb_owner_o          owner of the current/last transaction, 0 = IF, 1 = LS
module beta_imem_arbiter #(
    parameter int DataWidth   = 32,
    parameter int AddrWidth   = 32,
    parameter int StarveLimit = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   arb_if_req_i,
    input  logic [AddrWidth-1:0]   arb_if_addr_i,
    input  logic                   arb_if_flush_i,
    output logic                   arb_if_ready_o,
    output logic                   arb_if_valid_o,
    output logic [DataWidth-1:0]   arb_if_rdata_o,
    input  logic                   arb_ls_req_i,
    input  logic                   arb_ls_we_i,
    input  logic [DataWidth/8-1:0] arb_ls_be_i,
    input  logic [AddrWidth-1:0]   arb_ls_addr_i,
    input  logic [DataWidth-1:0]   arb_ls_wdata_i,
    output logic                   arb_ls_ready_o,
    output logic                   arb_ls_valid_o,
    output logic [DataWidth-1:0]   arb_ls_rdata_o,
    output logic                   arb_mem_req_o,
    output logic                   arb_mem_we_o,
    output logic [DataWidth/8-1:0] arb_mem_be_o,
    output logic [AddrWidth-1:0]   arb_mem_addr_o,
    output logic [DataWidth-1:0]   arb_mem_wdata_o,
    input  logic                   arb_mem_ready_i,
    input  logic                   arb_mem_valid_i,
    input  logic [DataWidth-1:0]   arb_mem_rdata_i,
    output logic                   arb_busy_o,
    output logic                   arb_owner_o
);

    localparam int BeWidth = DataWidth / 8;
    localparam logic [3:0] Limit = 4'(StarveLimit);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT_RSP} state_t;

    state_t                 state_q;
    logic                   owner_q;
    logic                   drop_q;
    logic [3:0]             starve_q;
    logic [DataWidth-1:0]   if_rdata_q;
    logic [DataWidth-1:0]   ls_rdata_q;

    logic                   idle_pick_ls;
    logic                   sel_ls;
    logic                   req_act;
    logic                   req_out;
    logic                   accept;
    logic                   rsp;
    logic                   rsp_if;
    logic                   rsp_ls;

    always_comb begin
        // Starvation guard overrides the default LS priority.
        idle_pick_ls = arb_ls_req_i && !((starve_q == Limit) && arb_if_req_i);
        sel_ls       = (state_q == IDLE) ? idle_pick_ls : owner_q;
        case (state_q)
            IDLE:    req_act = arb_if_req_i | arb_ls_req_i;
            HOLD:    req_act = owner_q ? arb_ls_req_i : arb_if_req_i;
            default: req_act = 1'b0;
        endcase
        // Gating with rstn_i keeps every output at 0 while reset is held,
        // even if requesters keep their req high.
        req_out = req_act & rstn_i;
        accept  = req_out & arb_mem_ready_i;
        rsp     = (state_q == WAIT_RSP) & arb_mem_valid_i & rstn_i;
        // A flush arriving together with the response still kills it.
        rsp_if  = rsp & ~owner_q & ~(drop_q | arb_if_flush_i);
        rsp_ls  = rsp & owner_q;
    end

    assign arb_mem_req_o   = req_out;
    assign arb_mem_we_o    = req_out & sel_ls & arb_ls_we_i;
    assign arb_mem_be_o    = !req_out ? '0 : (sel_ls ? arb_ls_be_i : {BeWidth{1'b1}});
    assign arb_mem_addr_o  = !req_out ? '0 : (sel_ls ? arb_ls_addr_i : arb_if_addr_i);
    assign arb_mem_wdata_o = (req_out && sel_ls) ? arb_ls_wdata_i : '0;

    assign arb_if_ready_o  = accept & ~sel_ls;
    assign arb_ls_ready_o  = accept & sel_ls;
    assign arb_if_valid_o  = rsp_if;
    assign arb_ls_valid_o  = rsp_ls;
    assign arb_if_rdata_o  = rsp_if ? arb_mem_rdata_i : if_rdata_q;
    assign arb_ls_rdata_o  = rsp_ls ? arb_mem_rdata_i : ls_rdata_q;
    assign arb_busy_o      = (state_q != IDLE);
    assign arb_owner_o     = owner_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            drop_q     <= 1'b0;
            starve_q   <= 4'd0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_act) begin
                        owner_q <= idle_pick_ls;
                        state_q <= arb_mem_ready_i ? WAIT_RSP : HOLD;
                    end
                end
                HOLD: begin
                    if (!owner_q && arb_if_flush_i) drop_q <= 1'b1;
                    if (!req_act) begin
                        // Owner withdrew before acceptance: nothing was issued.
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                    end else if (arb_mem_ready_i) begin
                        state_q <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (!owner_q && arb_if_flush_i) drop_q <= 1'b1;
                    if (arb_mem_valid_i) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept && !sel_ls) begin
                starve_q <= 4'd0;
            end else if (accept && sel_ls && arb_if_req_i) begin
                if (starve_q < Limit) starve_q <= starve_q + 4'd1;
            end else if (state_q == IDLE && !arb_if_req_i) begin
                starve_q <= 4'd0;
            end

            if (rsp_if) if_rdata_q <= arb_mem_rdata_i;
            if (rsp_ls) ls_rdata_q <= arb_mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_beta_imem_arbiter.sv
// tb/tb_beta_imem_arbiter.sv - self-checking bench for beta_imem_arbiter
module tb_beta_imem_arbiter;

    localparam int STARVE = 4;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        arb_if_req_i = 1'b0;
    logic [31:0] arb_if_addr_i = '0;
    logic        arb_if_flush_i = 1'b0;
    logic        arb_if_ready_o;
    logic        arb_if_valid_o;
    logic [31:0] arb_if_rdata_o;
    logic        arb_ls_req_i = 1'b0;
    logic        arb_ls_we_i = 1'b0;
    logic [3:0]  arb_ls_be_i = '0;
    logic [31:0] arb_ls_addr_i = '0;
    logic [31:0] arb_ls_wdata_i = '0;
    logic        arb_ls_ready_o;
    logic        arb_ls_valid_o;
    logic [31:0] arb_ls_rdata_o;
    logic        arb_mem_req_o;
    logic        arb_mem_we_o;
    logic [3:0]  arb_mem_be_o;
    logic [31:0] arb_mem_addr_o;
    logic [31:0] arb_mem_wdata_o;
    logic        arb_mem_ready_i = 1'b0;
    logic        arb_mem_valid_i = 1'b0;
    logic [31:0] arb_mem_rdata_i = '0;
    logic        arb_busy_o;
    logic        arb_owner_o;

    beta_imem_arbiter #(.DataWidth(32), .AddrWidth(32), .StarveLimit(STARVE)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .arb_if_req_i(arb_if_req_i), .arb_if_addr_i(arb_if_addr_i), .arb_if_flush_i(arb_if_flush_i),
        .arb_if_ready_o(arb_if_ready_o), .arb_if_valid_o(arb_if_valid_o), .arb_if_rdata_o(arb_if_rdata_o),
        .arb_ls_req_i(arb_ls_req_i), .arb_ls_we_i(arb_ls_we_i), .arb_ls_be_i(arb_ls_be_i),
        .arb_ls_addr_i(arb_ls_addr_i), .arb_ls_wdata_i(arb_ls_wdata_i),
        .arb_ls_ready_o(arb_ls_ready_o), .arb_ls_valid_o(arb_ls_valid_o), .arb_ls_rdata_o(arb_ls_rdata_o),
        .arb_mem_req_o(arb_mem_req_o), .arb_mem_we_o(arb_mem_we_o), .arb_mem_be_o(arb_mem_be_o),
        .arb_mem_addr_o(arb_mem_addr_o), .arb_mem_wdata_o(arb_mem_wdata_o),
        .arb_mem_ready_i(arb_mem_ready_i), .arb_mem_valid_i(arb_mem_valid_i), .arb_mem_rdata_i(arb_mem_rdata_i),
        .arb_busy_o(arb_busy_o), .arb_owner_o(arb_owner_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: one optional outstanding transaction record.
    bit          m_pend;      // a transaction has been presented (and not finished)
    bit          m_acc;       // that transaction has been accepted by memory
    bit          m_ls;        // it belongs to LS
    bit          m_drop;      // its fetch response has been made stale
    bit          m_owner;
    int          m_starve;    // LS grants since IF was last served while IF waited
    logic [31:0] m_if_rdata;
    logic [31:0] m_ls_rdata;
    bit          last_if_acc;
    bit          last_ls_acc;
    bit          grants[$];   // observed grant order, 1 = LS

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_acc = 0; m_ls = 0; m_drop = 0; m_owner = 0; m_starve = 0;
        m_if_rdata = '0; m_ls_rdata = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({arb_if_ready_o, arb_if_valid_o, arb_ls_ready_o, arb_ls_valid_o,
                      arb_mem_req_o, arb_mem_we_o, arb_mem_be_o, arb_busy_o, arb_owner_o}), 32'd0);
        chk({tag, "_data"}, arb_if_rdata_o | arb_ls_rdata_o | arb_mem_addr_o | arb_mem_wdata_o, 32'd0);
    endtask

    // Compare this cycle's outputs with the reference, then advance it.
    task automatic model_cycle();
        logic any, w_ls, e_req, e_acc, resp, e_ifv, e_lsv;
        any   = arb_if_req_i | arb_ls_req_i;
        w_ls  = 1'b0;
        e_req = 1'b0;
        if (!m_pend) begin
            e_req = any;
            w_ls  = arb_ls_req_i && !(m_starve == STARVE && arb_if_req_i);
        end else if (!m_acc) begin
            w_ls  = m_ls;
            e_req = m_ls ? arb_ls_req_i : arb_if_req_i;
        end else begin
            w_ls  = m_ls;
        end
        e_acc = e_req && arb_mem_ready_i;
        resp  = m_pend && m_acc && arb_mem_valid_i;
        e_ifv = resp && !m_ls && !(m_drop || arb_if_flush_i);
        e_lsv = resp && m_ls;
        if (e_ifv) m_if_rdata = arb_mem_rdata_i;
        if (e_lsv) m_ls_rdata = arb_mem_rdata_i;

        chk("mem_req", 32'(arb_mem_req_o), 32'(e_req));
        chk("mem_we", 32'(arb_mem_we_o), 32'(e_req && w_ls && arb_ls_we_i));
        chk("mem_be", 32'(arb_mem_be_o), !e_req ? 32'd0 : (w_ls ? 32'(arb_ls_be_i) : 32'hf));
        chk("mem_addr", arb_mem_addr_o, !e_req ? 32'd0 : (w_ls ? arb_ls_addr_i : arb_if_addr_i));
        chk("mem_wdata", arb_mem_wdata_o, (e_req && w_ls) ? arb_ls_wdata_i : 32'd0);
        chk("if_ready", 32'(arb_if_ready_o), 32'(e_acc && !w_ls));
        chk("ls_ready", 32'(arb_ls_ready_o), 32'(e_acc && w_ls));
        chk("if_valid", 32'(arb_if_valid_o), 32'(e_ifv));
        chk("ls_valid", 32'(arb_ls_valid_o), 32'(e_lsv));
        chk("if_rdata", arb_if_rdata_o, m_if_rdata);
        chk("ls_rdata", arb_ls_rdata_o, m_ls_rdata);
        chk("busy", 32'(arb_busy_o), 32'(m_pend));
        chk("owner", 32'(arb_owner_o), 32'(m_owner));

        if (arb_if_ready_o || arb_ls_ready_o) grants.push_back(arb_ls_ready_o);

        if (e_acc && !w_ls) m_starve = 0;
        else if (e_acc && w_ls && arb_if_req_i) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
        else if (!m_pend && !arb_if_req_i) m_starve = 0;

        last_if_acc = e_acc && !w_ls;
        last_ls_acc = e_acc && w_ls;
        if (!m_pend) begin
            if (any) begin
                m_pend = 1; m_ls = w_ls; m_owner = w_ls; m_acc = arb_mem_ready_i; m_drop = 0;
            end
        end else if (!m_acc) begin
            if (!e_req) m_pend = 0;
            else begin
                if (arb_if_flush_i && !m_ls) m_drop = 1;
                if (arb_mem_ready_i) m_acc = 1;
            end
        end else begin
            if (arb_if_flush_i && !m_ls) m_drop = 1;
            if (arb_mem_valid_i) m_pend = 0;
        end
    endtask

    task automatic cyc();
        #1;
        model_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        arb_if_req_i = 0; arb_ls_req_i = 0; arb_if_flush_i = 0; arb_ls_we_i = 0;
        arb_ls_be_i = '0; arb_mem_ready_i = 0; arb_mem_valid_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn_i = 0;
        @(posedge clk_i);
        #1;
        rstn_i = 1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #2;
        chk_all_zero("reset_state");
        do_reset();

        // IF-only read
        arb_if_req_i = 1; arb_if_addr_i = 32'h100; arb_mem_ready_i = 1;
        #1; chk("if_only_ready", 32'(arb_if_ready_o), 32'd1);
        cyc();
        arb_if_req_i = 0; arb_mem_ready_i = 0; cyc();
        arb_mem_valid_i = 1; arb_mem_rdata_i = 32'hDEADBEEF;
        #1; chk("if_only_valid", 32'(arb_if_valid_o), 32'd1);
        chk("if_only_rdata", arb_if_rdata_o, 32'hDEADBEEF);
        cyc();
        arb_mem_valid_i = 0;
        chk("if_only_idle", 32'(arb_busy_o), 32'd0);
        cyc();

        // Both requesting continuously, memory always ready/valid
        do_reset();
        grants.delete();
        arb_if_req_i = 1; arb_if_addr_i = 32'h200; arb_ls_req_i = 1; arb_ls_addr_i = 32'h300;
        arb_mem_ready_i = 1; arb_mem_valid_i = 1; arb_mem_rdata_i = 32'h55;
        for (int i = 0; i < 20; i++) cyc();
        chk("starve_count", 32'(grants.size()), 32'd10);
        for (int i = 0; i < 10 && i < grants.size(); i++)
            chk($sformatf("starve_grant%0d", i), 32'(grants[i]), (i % 5 == 4) ? 32'd0 : 32'd1);

        // Hold lock
        do_reset();
        arb_ls_req_i = 1; arb_ls_addr_i = 32'h400;
        for (int i = 0; i < 3; i++) begin
            #1; chk("hold_addr", arb_mem_addr_o, 32'h400);
            cyc();
            arb_if_req_i = 1; arb_if_addr_i = 32'h500;
        end
        arb_mem_ready_i = 1;
        #1; chk("hold_accept", 32'(arb_ls_ready_o), 32'd1);
        cyc();
        arb_ls_req_i = 0; arb_mem_valid_i = 1; arb_mem_rdata_i = 32'h77; cyc();
        arb_mem_valid_i = 0;
        #1; chk("hold_if_after", 32'(arb_if_ready_o), 32'd1);
        cyc();
        arb_if_req_i = 0; arb_mem_valid_i = 1; cyc();
        arb_mem_valid_i = 0; cyc();

        // Flush in WAIT_RSP, then flush coincident with valid
        for (int k = 0; k < 2; k++) begin
            do_reset();
            arb_if_req_i = 1; arb_if_addr_i = 32'h600; arb_mem_ready_i = 1; cyc();
            arb_if_req_i = 0; arb_mem_ready_i = 0;
            if (k == 0) begin arb_if_flush_i = 1; cyc(); arb_if_flush_i = 0; end
            else arb_if_flush_i = 1;
            arb_mem_valid_i = 1; arb_mem_rdata_i = 32'h1234;
            #1; chk("flush_valid", 32'(arb_if_valid_o), 32'd0);
            cyc();
            arb_mem_valid_i = 0; arb_if_flush_i = 0;
            chk("flush_idle", 32'(arb_busy_o), 32'd0);
            cyc();
        end

        // Store
        do_reset();
        arb_ls_req_i = 1; arb_ls_we_i = 1; arb_ls_be_i = 4'b0011; arb_ls_wdata_i = 32'hA5A5;
        arb_ls_addr_i = 32'h700; arb_mem_ready_i = 1;
        #1; chk("store_we", 32'(arb_mem_we_o), 32'd1);
        chk("store_be", 32'(arb_mem_be_o), 32'h3);
        chk("store_wdata", arb_mem_wdata_o, 32'hA5A5);
        cyc();
        arb_ls_req_i = 0; arb_mem_ready_i = 0; arb_mem_valid_i = 1; arb_mem_rdata_i = 32'h0;
        #1; chk("store_ack", 32'(arb_ls_valid_o), 32'd1);
        cyc();
        arb_mem_valid_i = 0; cyc();

        // Withdraw in HOLD
        arb_ls_req_i = 1; arb_ls_we_i = 0; arb_ls_be_i = 4'hf; arb_ls_addr_i = 32'h800; cyc();
        arb_ls_req_i = 0;
        #1; chk("withdraw_req", 32'(arb_mem_req_o), 32'd0);
        cyc(); cyc();

        // Async reset in WAIT_RSP
        arb_if_req_i = 1; arb_if_addr_i = 32'h900; arb_mem_ready_i = 1; cyc();
        arb_ls_req_i = 1; arb_mem_valid_i = 0;
        #2; rstn_i = 0;
        #1; chk_all_zero("async_reset");
        @(posedge clk_i); #1;
        idle_inputs(); rstn_i = 1; model_reset();
        arb_mem_valid_i = 1; arb_mem_rdata_i = 32'hBAD;
        #1; chk("reset_late_valid", 32'({arb_if_valid_o, arb_ls_valid_o}), 32'd0);
        cyc();
        arb_mem_valid_i = 0; cyc();

        // Randomized traffic against the reference
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (last_if_acc) arb_if_req_i = 1'($urandom_range(0, 1));
            if (!arb_if_req_i && $urandom_range(0, 2) == 0) begin
                arb_if_req_i = 1; arb_if_addr_i = $urandom;
            end
            if (last_ls_acc) arb_ls_req_i = 1'($urandom_range(0, 1));
            if (!arb_ls_req_i && $urandom_range(0, 2) == 0) begin
                arb_ls_req_i = 1; arb_ls_addr_i = $urandom; arb_ls_wdata_i = $urandom;
                arb_ls_we_i = 1'($urandom_range(0, 1)); arb_ls_be_i = 4'($urandom_range(0, 15));
            end
            arb_mem_ready_i = ($urandom_range(0, 9) < 6);
            arb_mem_valid_i = (m_pend && m_acc) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            arb_mem_rdata_i = $urandom;
            arb_if_flush_i  = ($urandom_range(0, 9) == 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
